mips_boot_sequencer: RTL
========================

# mips_boot_sequencer

Sequencing controller that sits beside the pipelined MIPS core and drives its external loading and start interface. It accepts a word stream carrying a program image, writes the instruction words into the I-cache and the data words into the D-cache, and then pulses `start`. It then supervises execution until the core signals halt or a cycle budget expires, and reports the outcome.

## Interface
- `IMEM_DEPTH`, default 256: maximum instruction word count accepted.
- `DMEM_DEPTH`, default 256: maximum data word count accepted.
- `MAX_CYCLES`, default 100000: run-cycle budget before timeout; must be at least 1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `go` in 1: begin a load/run sequence; sampled only in IDLE, DONE or ERR.
- `abort` in 1: return to IDLE from any state; has priority over every other input.
- `in_valid` in 1: image stream word valid.
- `in_data` in 32: image stream word.
- `in_ready` out 1: sequencer accepts `in_data` this cycle.
- `halt_i` in 1: core finished; level-sensitive, sampled only in RUN.
- `IData_in` out 32: I-cache write data.
- `IAddr_in` out 32: I-cache word address.
- `icache_we` out 1: I-cache write enable.
- `DData_in` out 32: D-cache write data.
- `DAddr_in` out 32: D-cache word address.
- `dcache_we` out 1: D-cache write enable.
- `start` out 1: one-cycle start pulse to the core.
- `busy` out 1: high in every state except IDLE, DONE and ERR.
- `done` out 1: run ended by `halt_i`; held until the next `go` or `abort`.
- `err` out 1: sequence failed; held until the next `go` or `abort`.
- `err_code` out 2: 0 none, 1 bad instruction count, 2 bad data count, 3 timeout.
- `run_cycles` out 32: RUN-state cycle count; valid when `done` or `err` is set.

## Operation
- Accept rule: a word is consumed on a cycle where `in_valid && in_ready`.
- `in_ready` is high only in HDR_I, HDR_D, LOAD_I and LOAD_D. It is combinational from state.
- Image format: word 0 is N_I, word 1 is N_D, then N_I instruction words, then N_D data words.
- States: IDLE, HDR_I, HDR_D, LOAD_I, LOAD_D, START, RUN, DONE, ERR.
- IDLE, DONE or ERR, with `go` high: go to HDR_I. Clear `done`, `err`, `err_code`, `run_cycles` and both address counters.
- HDR_I, on accept:
  - N_I = 0 or N_I > IMEM_DEPTH: go to ERR with code 1.
  - Otherwise latch N_I and go to HDR_D.
- HDR_D, on accept:
  - N_D > DMEM_DEPTH: go to ERR with code 2.
  - Otherwise latch N_D and go to LOAD_I.
- LOAD_I: each accepted word k (k = 0..N_I-1) is written to I-cache address k. After word N_I-1, go to LOAD_D if N_D ≠ 0, otherwise go to START.
- LOAD_D: each accepted word k is written to D-cache address k. After word N_D-1, go to START.
- START: lasts one cycle, then go to RUN.
- RUN:
  - `run_cycles` increments every cycle.
  - `halt_i` high: go to DONE.
  - `run_cycles` reaches MAX_CYCLES-1 without `halt_i`: go to ERR with code 3.
  - If both happen in the same cycle, halt wins.
- Ignored inputs: `go` is ignored while `busy`. `halt_i` is ignored outside RUN. Stream words are never consumed outside the load states.
- `abort`: go to IDLE next cycle. All outputs return to reset values. Any partially loaded cache contents are left as written.
- Widths: address counters are 32 bits and zero-extended. N_I and N_D use the full 32-bit compare, with no truncation.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready`, `icache_we`, `dcache_we`, `start`, `busy`, `done` and `err` are 0.
  - `err_code`, `run_cycles`, `IData_in`, `IAddr_in`, `DData_in` and `DAddr_in` are 0.
- Reset asserted mid-sequence aborts immediately and asynchronously.
- Cache writes are registered. A word accepted in cycle c produces `*_we` = 1 with matching address and data in cycle c+1, for exactly one cycle per word.
- With a continuous stream, one write happens per cycle and the enable stays high back-to-back.
- The last load word is accepted in cycle c. The state is START in cycle c+1, and the final write-enable also occurs in c+1. `start` = 1 in cycle c+2 only, and the state is RUN in c+2.
- `run_cycles` is 0 in the first RUN cycle. If `halt_i` is high in RUN cycle n (counting from 0), then `done` = 1 and `run_cycles` = n+1 in the next cycle.
- Header errors: ERR and `err` are visible the cycle after the offending word is accepted.
- `busy`, `done`, `err` and `err_code` are registered and track state with no extra latency.

## Test plan
- Nominal load and halt:
  - Stimulus: `go`, then stream 3, 2, 0x20010001, 0x20020002, 0x00221820, 0xA, 0xB with `in_valid` held high.
  - Required: IAddr 0/1/2 written in consecutive cycles, then DAddr 0/1 in consecutive cycles.
  - Required: `start` pulses two cycles after the last accept.
  - Required: `halt_i` in RUN cycle 9 gives `done` = 1 and `run_cycles` = 10.
- Zero data words:
  - Stimulus: stream 1, 0, 0x20010001.
  - Required: no `dcache_we` ever asserts.
  - Required: `start` pulses two cycles after the instruction word is accepted.
- Bad headers:
  - Stimulus: N_I = 0, or N_I = IMEM_DEPTH+1, or N_D = DMEM_DEPTH+1.
  - Required: `err` = 1 with `err_code` 1, 1 and 2 respectively, and no cache write occurs.
- Timeout:
  - Stimulus: MAX_CYCLES = 16, `halt_i` tied low.
  - Required: `err_code` = 3 and `run_cycles` = 16.
  - Stimulus: `halt_i` and the timeout in the same cycle.
  - Required: DONE, not ERR.
- Bubbles and abort:
  - Stimulus: toggle `in_valid` randomly during the load.
  - Required: addresses stay contiguous and `we` asserts only the cycle after an accept.
  - Stimulus: assert `abort` mid-LOAD_I.
  - Required: IDLE next cycle, all outputs 0, and a new `go` restarts at address 0.
- Reset and restart:
  - Stimulus: assert `rst` during RUN.
  - Required: immediate return to reset values.
  - Stimulus: `go` from DONE.
  - Required: `done` clears and a second image loads correctly.

Source files
------------

// File: rtl/mips_boot_sequencer.sv
// Boot sequencer for the pipelined MIPS core: loads a program image from a word
// stream into the I/D caches, pulses start, then supervises the run to halt or timeout.
module mips_boot_sequencer #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        halt_i,
  output logic [31:0] IData_in,
  output logic [31:0] IAddr_in,
  output logic        icache_we,
  output logic [31:0] DData_in,
  output logic [31:0] DAddr_in,
  output logic        dcache_we,
  output logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] run_cycles
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_I, S_HDR_D, S_LOAD_I, S_LOAD_D, S_START, S_RUN, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0]  ERR_NONE    = 2'd0;
  localparam logic [1:0]  ERR_ICNT    = 2'd1;
  localparam logic [1:0]  ERR_DCNT    = 2'd2;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd3;
  localparam logic [31:0] I_LIMIT     = 32'(IMEM_DEPTH);
  localparam logic [31:0] D_LIMIT     = 32'(DMEM_DEPTH);
  localparam logic [31:0] RUN_LAST    = 32'(MAX_CYCLES - 1);

  state_t      state, state_nx;
  logic [1:0]  code_nx;
  logic [31:0] n_i, n_d, i_cnt, d_cnt;
  logic        accept, launch, last_i, last_d, idle_like;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
  assign in_ready  = (state == S_HDR_I) || (state == S_HDR_D) ||
                     (state == S_LOAD_I) || (state == S_LOAD_D);
  assign accept    = in_valid && in_ready && !abort;
  assign launch    = go && idle_like && !abort;
  assign last_i    = (i_cnt == n_i - 32'd1);
  assign last_d    = (d_cnt == n_d - 32'd1);

  // NOTE: defaults first so every path assigns state_nx and code_nx; no latch is inferred.
  always_comb begin
    state_nx = state;
    code_nx  = ERR_NONE;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (go) state_nx = S_HDR_I;
        S_HDR_I: if (accept) begin
          if (in_data == 32'd0 || in_data > I_LIMIT) begin
            state_nx = S_ERR;
            code_nx  = ERR_ICNT;
          end else begin
            state_nx = S_HDR_D;
          end
        end
        S_HDR_D: if (accept) begin
          if (in_data > D_LIMIT) begin
            state_nx = S_ERR;
            code_nx  = ERR_DCNT;
          end else begin
            state_nx = S_LOAD_I;
          end
        end
        S_LOAD_I: if (accept && last_i) state_nx = (n_d != 32'd0) ? S_LOAD_D : S_START;
        S_LOAD_D: if (accept && last_d) state_nx = S_START;
        S_START:  state_nx = S_RUN;
        S_RUN: begin
          // Halt is checked first so it wins over a same-cycle timeout.
          if (halt_i) begin
            state_nx = S_DONE;
          end else if (run_cycles == RUN_LAST) begin
            state_nx = S_ERR;
            code_nx  = ERR_TIMEOUT;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_i        <= '0;
      n_d        <= '0;
      i_cnt      <= '0;
      d_cnt      <= '0;
      IData_in   <= '0;
      IAddr_in   <= '0;
      icache_we  <= 1'b0;
      DData_in   <= '0;
      DAddr_in   <= '0;
      dcache_we  <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      run_cycles <= '0;
    end else if (abort) begin
      n_i        <= '0;
      n_d        <= '0;
      i_cnt      <= '0;
      d_cnt      <= '0;
      IData_in   <= '0;
      IAddr_in   <= '0;
      icache_we  <= 1'b0;
      DData_in   <= '0;
      DAddr_in   <= '0;
      dcache_we  <= 1'b0;
      start      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      run_cycles <= '0;
    end else begin
      icache_we <= 1'b0;
      dcache_we <= 1'b0;
      start     <= (state == S_START);
      busy      <= !((state_nx == S_IDLE) || (state_nx == S_DONE) || (state_nx == S_ERR));
      done      <= (state_nx == S_DONE);
      err       <= (state_nx == S_ERR);
      if (state_nx != S_ERR)  err_code <= ERR_NONE;
      else if (state != S_ERR) err_code <= code_nx;

      if (launch) begin
        run_cycles <= '0;
        i_cnt      <= '0;
        d_cnt      <= '0;
      end else if (state == S_RUN) begin
        run_cycles <= run_cycles + 32'd1;
      end

      if (accept) begin
        case (state)
          S_HDR_I: n_i <= in_data;
          S_HDR_D: n_d <= in_data;
          S_LOAD_I: begin
            icache_we <= 1'b1;
            IAddr_in  <= i_cnt;
            IData_in  <= in_data;
            i_cnt     <= i_cnt + 32'd1;
          end
          S_LOAD_D: begin
            dcache_we <= 1'b1;
            DAddr_in  <= d_cnt;
            DData_in  <= in_data;
            d_cnt     <= d_cnt + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
